// File: rtl/vga_fb_scanner.sv
// vga_fb_scanner: 640x480@60 VGA scanner reading a tile-based framebuffer.
// The framebuffer holds one 32x32-pixel tile per word (20x15 tiles from FB_BASE),
// and each word's low 12 bits give an RGB444 colour.
// Pipeline: counters -> stage A (address, flags) -> stage B (pins). Both stages
// advance on the pixel tick, so rgb/hsync/vsync lag the counters by two ticks.
// vblank is registered in stage B directly from the live vertical counter.
module vga_fb_scanner #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FB_BASE    = 0,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] dispAddr,
  input  logic [DATA_WIDTH-1:0] dispColor,
  output logic [11:0]           rgb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int DIVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0]       DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] FB_BASE_A = ADDR_WIDTH'(FB_BASE);

  logic [DIVW-1:0] div_cnt;
  logic [9:0]      h_cnt;
  logic [9:0]      v_cnt;
  logic            tick;
  logic            h_last;
  logic            v_last;
  logic            active;
  logic            hs_region;
  logic            vs_region;
  logic [3:0]      row;
  logic [4:0]      col;
  logic [ADDR_WIDTH-1:0] addr;

  // Stage-A registers
  logic act_a;
  logic hs_a;
  logic vs_a;

  assign tick      = en && (div_cnt == DIV_LAST);
  assign h_last    = (h_cnt == 10'd799);
  assign v_last    = (v_cnt == 10'd524);
  assign active    = (h_cnt < 10'd640) && (v_cnt < 10'd480);
  assign hs_region = (h_cnt >= 10'd656) && (h_cnt < 10'd752);
  assign vs_region = (v_cnt >= 10'd490) && (v_cnt < 10'd492);

  // Tile index: row*20 + col built from shifts so no multiplier is inferred.
  assign row  = v_cnt[8:5];
  assign col  = h_cnt[9:5];
  assign addr = FB_BASE_A + ADDR_WIDTH'({row, 4'b0000}) + ADDR_WIDTH'({row, 2'b00})
              + ADDR_WIDTH'(col);

  // Upper data bits carry no colour information.
  generate
    if (DATA_WIDTH > 12) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^dispColor[DATA_WIDTH-1:12];
    end
  endgenerate

  // Pixel-clock divider; frozen while the scan is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + DIVW'(1);
    end
  end

  // Horizontal and vertical position counters, advancing one pixel per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= 10'd0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Stage A: present the framebuffer address and delay the timing flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dispAddr <= FB_BASE_A;
      act_a    <= 1'b0;
      hs_a     <= 1'b1;
      vs_a     <= 1'b1;
    end else if (tick) begin
      dispAddr <= active ? addr : FB_BASE_A;
      act_a    <= active;
      hs_a     <= !hs_region;
      vs_a     <= !vs_region;
    end
  end

  // Stage B: register the returned colour and syncs; blank at once when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb    <= 12'h000;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      vblank <= 1'b0;
    end else if (!en) begin
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      rgb    <= act_a ? dispColor[11:0] : 12'h000;
      hsync  <= hs_a;
      vsync  <= vs_a;
      vblank <= (v_cnt >= 10'd480);
    end
  end

  // One-clock pulse on the tick that wraps the last pixel of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_last && v_last;
    end
  end

endmodule

// File: doc/vga_fb_scanner.md
Name: vga_fb_scanner

Overview:
- Display-side consumer of the data RAM's second read port.
- Sweeps 640x480@60 VGA timing, drives the RAM display address and samples the returned display word.
- Emits registered RGB444 plus negative-polarity hsync/vsync to the board's VGA pins.
- Framebuffer is tile-based: 32x32-pixel tiles, 20x15 = 300 words starting at FB_BASE.
- One colour per word, taken from bits [11:0] as R[11:8] G[7:4] B[3:0].

Parameters:
- ADDR_WIDTH, 10, width of dispAddr; must match the RAM.
- DATA_WIDTH, 32, width of dispColor.
- FB_BASE, 0, word address of tile (0,0).
- CLK_DIV, 4, system clocks per pixel; legal range is >= 2. The default gives 25 MHz pixels from 100 MHz.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low freezes timing and blanks the output.
- dispAddr  out  ADDR_WIDTH  framebuffer word address (registered).
- dispColor  in  DATA_WIDTH  word at dispAddr; combinational or valid within 1 clk.
- rgb  out  12  pixel colour (registered).
- hsync  out  1  horizontal sync, active low (registered).
- vsync  out  1  vertical sync, active low (registered).
- vblank  out  1  high while v_cnt >= 480 (registered).
- frame_start  out  1  one-clk pulse at frame wrap.

Behaviour:
- Clocking: single clock domain. Reset is asynchronous and active-high, named rst as in the rest of the design.
- Reset values:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0.
  - dispAddr = FB_BASE; rgb = 0.
  - hsync = 1, vsync = 1.
  - vblank = 0, frame_start = 0.
  - Stage-A flags: act_a = 0, hs_a = 1, vs_a = 1.
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick = en && div_cnt == CLK_DIV-1.
  - div_cnt advances only while en = 1.
- Horizontal timing, h_cnt 0..799:
  - Active 0..639, front porch 640..655.
  - Sync 656..751, back porch 752..799.
- Vertical timing, v_cnt 0..524:
  - Active 0..479, front porch 480..489.
  - Sync 490..491, back porch 492..524.
- Counter advance on tick:
  - h_cnt increments; at 799 it wraps to 0 and v_cnt increments.
  - At v_cnt 524 with h_cnt 799, v_cnt wraps to 0.
- Address map:
  - col = h_cnt[9:5] (0..19); row = v_cnt[8:5] (0..14).
  - addr = FB_BASE + row*20 + col, computed as (row<<4)+(row<<2)+col.
  - Result is truncated modulo 2^ADDR_WIDTH. No multiplier.
- Two-stage pipeline; both stages update only on tick. For current counters (h, v):
  - Stage A: dispAddr <= active ? addr : FB_BASE. act_a <= active. hs_a <= !hsync_region. vs_a <= !vsync_region.
  - Stage B: rgb <= act_a ? dispColor[11:0] : 12'h000. hsync <= hs_a. vsync <= vs_a. vblank <= (v >= 480).
  - Net latency: counters to pins = 2 ticks, with rgb, hsync and vsync mutually aligned.
  - dispColor is sampled CLK_DIV-1 >= 1 clks after dispAddr changes. This covers both combinational and 1-cycle-registered RAM reads.
- frame_start:
  - High for exactly one clk, on the clk of the tick where h = 799 and v = 524.
  - Low on every other clk.
- en low:
  - div_cnt, h_cnt, v_cnt and the stage-A registers hold.
  - Outputs force rgb = 0, hsync = 1, vsync = 1 and frame_start = 0 on the next clk.
  - dispAddr holds its value.
  - When en returns high, the scan resumes from the held counters.
- Reset asserted mid-frame: all state returns to the reset values immediately (asynchronous). The scan restarts at (0,0) on release.
- DATA_WIDTH bits [DATA_WIDTH-1:12] of dispColor are ignored.

Test Plan:
- Tile colour at origin: preload word FB_BASE = 32'h0000_0ABC, release reset, en = 1 -> rgb = 12'hABC appears 2 ticks (8 clk) after h = 0, v = 0, and holds for 32 pixels (128 clk).
- Last tile: word FB_BASE+299 = 32'h0000_0F0F -> dispAddr = 299 while h in 608..639 and v in 448..479; rgb = 12'hF0F at pixel (639,479).
- Horizontal timing: hsync low for exactly 384 clk in every 3200-clk line period. rgb = 0 outside the 2560-clk active window.
- Vertical timing: vsync low for exactly 6400 clk per frame. Frame period = 1,680,000 clk. frame_start pulses once per frame, 1 clk wide. vblank is high for 45 lines (144,000 clk) per frame.
- en toggle: drop en at h = 100, v = 10 for 50 clk -> rgb = 0 and syncs = 1 during the gap; the scan resumes at h = 100 with no skipped pixel.
- Reset mid-frame: assert rst at v = 300 -> next clk shows hsync = 1, vsync = 1, rgb = 0, dispAddr = FB_BASE; after release, the first frame_start arrives 1,680,000 clk later.
